frame_fifo: RTL and testbench
=============================

Name: frame_fifo

Overview:
- Parametrised single-clock FIFO; successor to the fixed 9-bit raw byte FIFO.
- Generalised in width and depth, with programmable almost-full and almost-empty thresholds and occupancy counts.
- Adds frame commit/discard: written words become visible to the reader only after `commit`, so a MAC receive path can drop a bad frame (CRC error or overflow) without the reader ever seeing it.
- Sits between the Ethernet RX byte stream (bit 8 = end-of-frame marker) and the packet consumer.

Parameters:
- DATA_WIDTH, 9, word width in bits.
- ADDR_WIDTH, 11, log2 of depth; DEPTH = 2**ADDR_WIDTH.
- AF_LEVEL, 1992, afull_flag asserts when wr_count >= AF_LEVEL.
- AE_LEVEL, 64, aempty_flag asserts when rd_count <= AE_LEVEL.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- di  in  DATA_WIDTH  write data.
- commit  in  1  publish all words written since the last commit/discard.
- discard  in  1  drop all uncommitted words.
- re  in  1  read enable (acknowledge in FWFT mode).
- do  out  DATA_WIDTH  read data.
- empty_flag  out  1  no committed word available.
- full_flag  out  1  no free storage, counting uncommitted words.
- aempty_flag  out  1  committed level <= AE_LEVEL.
- afull_flag  out  1  used level >= AF_LEVEL.
- rd_count  out  ADDR_WIDTH+1  committed words readable.
- wr_count  out  ADDR_WIDTH+1  words held, committed plus uncommitted.
- drop_pulse  out  1  one-cycle pulse when a frame is discarded, explicitly or by overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers rp, wp_c and wp_t = 0; do = 0; ovf = 0; drop_pulse = 0.
  - empty_flag = 1, aempty_flag = 1, full_flag = 0, afull_flag = 0, counts = 0.
  - Memory contents are not cleared.
  - Reset mid-frame loses all data, committed and uncommitted.
- Pointers:
  - All pointers are ADDR_WIDTH+1 bits; the MSB is a wrap bit. Addresses are pointer[ADDR_WIDTH-1:0].
  - All arithmetic is modulo 2**(ADDR_WIDTH+1).
  - wr_count = wp_t - rp; rd_count = wp_c - rp.
  - full_flag = (wr_count == DEPTH); empty_flag = (rd_count == 0).
- Flags and counts are registered and reflect state after the current edge, with no extra lag.
- Write:
  - we && !full_flag: mem[wp_t] <= di; wp_t++.
  - we && full_flag: word dropped and sticky ovf set; pointers unchanged.
- Commit:
  - commit && !ovf: wp_c <= wp_t, including any word written in the same cycle.
  - commit && ovf: treated as discard.
- Discard: wp_t <= wp_c; any same-cycle write is also dropped; ovf cleared; drop_pulse = 1 next cycle.
- commit and discard in the same cycle: discard wins.
- commit with no new words: no-op; no pulse.
- Read:
  - re && !empty_flag: do <= mem[rp] on the edge; rp++. Data is valid in the cycle after re.
  - re while empty_flag: ignored; do holds its value.
- Simultaneous read and write/commit are legal in every combination.
  - Read uses the pre-edge empty_flag.
  - A commit in the same cycle makes the data readable from the next cycle.
- Wrap-around: pointers wrap at 2*DEPTH. full/empty are distinguished by the wrap bit; no slot is wasted, so all DEPTH words are usable.

Optional Feature:
- Macro FRAME_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - do presents the head committed word, driven from a prefetch output register, whenever empty_flag = 0.
  - re acknowledges that word and advances.
  - Data appears on do 1 cycle after the commit edge that made it available.
  - empty_flag means the output register is invalid; rd_count includes the word held in the output register.
- Undefined: standard mode as above, with 1-cycle read latency.

Test Plan (ADDR_WIDTH=4, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2, DATA_WIDTH=9):
- Write 0x101..0x105 without commit -> empty_flag=1, rd_count=0, wr_count=5. Then commit -> next cycle empty_flag=0, rd_count=5. Read 5 words -> do=0x101..0x105 in order, then empty_flag=1.
- Commit frame A (3 words); write 4 words of frame B; discard -> drop_pulse=1 for one cycle, wr_count=3. Reads return only frame A.
- Write 17 words then commit -> 17th word dropped, full_flag=1 after the 16th write, commit acts as discard, drop_pulse=1, wr_count=0, empty_flag=1.
- Wrap test: commit/read 10 words three times with interleaved read/write -> data intact, counts correct across the pointer wrap. At level 12, afull_flag=1; at level 2, aempty_flag=1.
- Assert commit and discard in the same cycle as a we -> frame dropped, including the same-cycle word. Also assert rst_n low mid-frame -> all flags and counts return to reset values immediately.
- With FRAME_FIFO_FWFT_EN: commit 0x1AA alone -> do=0x1AA and empty_flag=0 one cycle after commit, without re. Then re -> empty_flag=1.

Source files
------------

// File: rtl/frame_fifo.sv
// frame_fifo: single-clock frame FIFO with commit/discard, programmable
// almost-full/almost-empty thresholds and registered occupancy counts.
// Written words stay invisible to the reader until committed; a discard
// (explicit, or a commit after an overflow) rolls the write pointer back.
// Optional macro FRAME_FIFO_FWFT_EN selects first-word fall-through output
// through a prefetch register; otherwise reads have one cycle of latency.
// The read data port is named dout because 'do' is a SystemVerilog keyword.
module frame_fifo #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned AF_LEVEL   = 1992,
    parameter int unsigned AE_LEVEL   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  commit,
    input  logic                  discard,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty_flag,
    output logic                  full_flag,
    output logic                  aempty_flag,
    output logic                  afull_flag,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  drop_pulse
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AF_P    = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_P    = ptr_t'(AE_LEVEL);
    localparam ptr_t ONE     = ptr_t'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t rp, wp_c, wp_t;
    ptr_t rp_d, wp_c_d, wp_t_d;
    ptr_t rd_count_d, wr_count_d, occ;
    logic ovf, ovf_d;
    logic rd_fire, wr_ok, ovf_hit, drop, load, empty_d;

    // Next-state pointers, flags and counts as they will be after this edge.
    always_comb begin
        rd_fire = re && !empty_flag;
        wr_ok   = we && !full_flag;
        ovf_hit = we && full_flag;
        // A commit after (or during) an overflow cannot publish a truncated frame.
        drop    = discard || (commit && (ovf || ovf_hit));

        wp_t_d = wr_ok ? wp_t + ONE : wp_t;
        wp_c_d = wp_c;
        ovf_d  = ovf || ovf_hit;
        if (drop) begin
            wp_t_d = wp_c;
            ovf_d  = 1'b0;
        end else if (commit) begin
            wp_c_d = wp_t_d;
        end

`ifdef FRAME_FIFO_FWFT_EN
        // Refill the output register from memory when it is free or being taken.
        // Only pre-edge committed words are eligible, so data lands one cycle
        // after the commit edge.
        load    = (wp_c != rp) && (empty_flag || rd_fire);
        empty_d = !load && (empty_flag || rd_fire);
        occ     = empty_d ? '0 : ONE;
        rp_d    = load ? rp + ONE : rp;
`else
        load    = rd_fire;
        occ     = '0;
        rp_d    = load ? rp + ONE : rp;
        empty_d = (wp_c_d == rp_d);
`endif

        // The output register word (FWFT) still counts as held and readable.
        rd_count_d = wp_c_d - rp_d + occ;
        wr_count_d = wp_t_d - rp_d + occ;
    end

    // Storage array: no reset, written only into free slots.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp_t[ADDR_WIDTH-1:0]] <= di;
        end
    end

    // Pointers, sticky overflow, output data and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp          <= '0;
            wp_c        <= '0;
            wp_t        <= '0;
            ovf         <= 1'b0;
            drop_pulse  <= 1'b0;
            dout        <= '0;
            empty_flag  <= 1'b1;
            aempty_flag <= 1'b1;
            full_flag   <= 1'b0;
            afull_flag  <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            rp          <= rp_d;
            wp_c        <= wp_c_d;
            wp_t        <= wp_t_d;
            ovf         <= ovf_d;
            drop_pulse  <= drop;
            if (load) begin
                dout <= mem[rp[ADDR_WIDTH-1:0]];
            end
            empty_flag  <= empty_d;
            aempty_flag <= (rd_count_d <= AE_P);
            full_flag   <= (wr_count_d == DEPTH_P);
            afull_flag  <= (wr_count_d >= AF_P);
            rd_count    <= rd_count_d;
            wr_count    <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_frame_fifo.sv
// Self-checking bench for frame_fifo (DEPTH=16, AF_LEVEL=12, AE_LEVEL=2).
// Committed words are pushed to a scoreboard queue; reads pop and compare.
// Also builds with FRAME_FIFO_FWFT_EN defined.
module tb_frame_fifo;

    localparam int DW = 9;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic          commit = 1'b0;
    logic          discard = 1'b0;
    logic          re = 1'b0;
    logic [DW-1:0] di = '0;
    logic [DW-1:0] dout;
    logic          empty_flag, full_flag, aempty_flag, afull_flag, drop_pulse;
    logic [AW:0]   rd_count, wr_count;

    int            n_cmp = 0;
    int            n_fail = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend[$];
    bit            m_ovf = 1'b0;

    frame_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (12),
        .AE_LEVEL  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .di         (di),
        .commit     (commit),
        .discard    (discard),
        .re         (re),
        .dout       (dout),
        .empty_flag (empty_flag),
        .full_flag  (full_flag),
        .aempty_flag(aempty_flag),
        .afull_flag (afull_flag),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
`ifdef FRAME_FIFO_FWFT_EN
        cycle();
`endif
    endtask

    function automatic logic [AW:0] m_wr();
        return (AW+1)'(exp_q.size() + pend.size());
    endfunction

    function automatic logic [AW:0] m_rd();
        return (AW+1)'(exp_q.size());
    endfunction

    task automatic model_write(input logic [DW-1:0] d);
        if (exp_q.size() + pend.size() < 16) pend.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic model_discard();
        pend.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_commit();
        if (m_ovf) begin
            model_discard();
        end else begin
            while (pend.size() > 0) exp_q.push_back(pend.pop_front());
        end
    endtask

    task automatic wr_word(input logic [DW-1:0] d, input bit c);
        we = 1'b1;
        di = d;
        commit = c;
        cycle();
        we = 1'b0;
        commit = 1'b0;
        model_write(d);
        if (c) model_commit();
    endtask

    task automatic commit_only();
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        model_commit();
    endtask

    // Returns the word the read delivers; X if no word ever became available.
    task automatic read_word(output logic [DW-1:0] got);
`ifdef FRAME_FIFO_FWFT_EN
        int k = 0;
        while (empty_flag && k < 4) begin
            cycle();
            k++;
        end
        got = empty_flag ? 'x : dout;
        re = 1'b1;
        cycle();
        re = 1'b0;
`else
        re = 1'b1;
        cycle();
        re = 1'b0;
        got = dout;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if ({empty_flag, aempty_flag, full_flag, afull_flag, drop_pulse} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 11000",
                     {empty_flag, aempty_flag, full_flag, afull_flag, drop_pulse});
        end
        n_cmp++;
        if ({rd_count, wr_count, dout} !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: rd %0d wr %0d dout %h expected 0/0/000",
                     rd_count, wr_count, dout);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_frame_visibility();
        logic [DW-1:0] got, want;
        for (int i = 0; i < 5; i++) wr_word(9'(9'h101 + i), 1'b0);
        n_cmp++;
        if ({empty_flag, rd_count, wr_count} !== {1'b1, 5'd0, 5'd5}) begin
            n_fail++;
            $display("FAIL uncommitted: empty %b rd %0d wr %0d expected 1/0/5",
                     empty_flag, rd_count, wr_count);
        end
        commit_only();
        settle();
        n_cmp++;
        if ({empty_flag, rd_count} !== {1'b0, 5'd5}) begin
            n_fail++;
            $display("FAIL committed: empty %b rd %0d expected 0/5", empty_flag, rd_count);
        end
        for (int i = 0; i < 5; i++) begin
            read_word(got);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL visible_data[%0d]: got %h expected %h", i, got, want);
            end
        end
        n_cmp++;
        if ({empty_flag, wr_count} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL drained: empty %b wr %0d expected 1/0", empty_flag, wr_count);
        end
    endtask

    task automatic test_discard();
        logic [DW-1:0] got, want;
        for (int i = 0; i < 3; i++) wr_word(9'(9'h0A1 + i), i == 2);
        for (int i = 0; i < 4; i++) wr_word(9'(9'h0B1 + i), 1'b0);
        discard = 1'b1;
        cycle();
        discard = 1'b0;
        model_discard();
        n_cmp++;
        if ({drop_pulse, wr_count, rd_count} !== {1'b1, m_wr(), m_rd()}) begin
            n_fail++;
            $display("FAIL discard: drop %b wr %0d rd %0d expected 1/%0d/%0d",
                     drop_pulse, wr_count, rd_count, m_wr(), m_rd());
        end
        cycle();
        n_cmp++;
        if (drop_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_one_cycle: got %b expected 0", drop_pulse);
        end
        for (int i = 0; i < 3; i++) begin
            read_word(got);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL frame_a[%0d]: got %h expected %h", i, got, want);
            end
        end
        n_cmp++;
        if (empty_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_b_hidden: empty %b expected 1", empty_flag);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] got;
        for (int i = 0; i < 16; i++) wr_word(9'(9'h110 + i), 1'b0);
        n_cmp++;
        if ({full_flag, afull_flag, wr_count} !== {1'b1, 1'b1, 5'd16}) begin
            n_fail++;
            $display("FAIL full_at_16: full %b afull %b wr %0d expected 1/1/16",
                     full_flag, afull_flag, wr_count);
        end
        wr_word(9'h1FF, 1'b0);
        n_cmp++;
        if ({full_flag, wr_count, drop_pulse} !== {1'b1, 5'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL word_17: full %b wr %0d drop %b expected 1/16/0",
                     full_flag, wr_count, drop_pulse);
        end
        commit_only();
        n_cmp++;
        if ({drop_pulse, wr_count, empty_flag, full_flag} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_commit: drop %b wr %0d empty %b full %b expected 1/0/1/0",
                     drop_pulse, wr_count, empty_flag, full_flag);
        end
        // Overflow must be cleared: the next frame commits normally.
        wr_word(9'h155, 1'b1);
        settle();
        read_word(got);
        n_cmp++;
        if (got !== 9'h155) begin
            n_fail++;
            $display("FAIL after_ovf: got %h expected 155", got);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_wrap();
        int rd_n[3] = '{8, 8, 14};
        logic [DW-1:0] v = 9'h0C0;
        logic [DW-1:0] got, want;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                wr_word(v, i == 9);
                v = v + 9'd1;
            end
            settle();
            n_cmp++;
            if ({wr_count, rd_count, afull_flag, aempty_flag} !==
                {m_wr(), m_rd(), m_wr() >= 12, m_rd() <= 2}) begin
                n_fail++;
                $display("FAIL wrap_fill[%0d]: wr %0d rd %0d af %b ae %b expected %0d/%0d/%b/%b",
                         r, wr_count, rd_count, afull_flag, aempty_flag,
                         m_wr(), m_rd(), m_wr() >= 12, m_rd() <= 2);
            end
            for (int j = 0; j < rd_n[r]; j++) begin
                read_word(got);
                want = exp_q.pop_front();
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL wrap_data[%0d.%0d]: got %h expected %h", r, j, got, want);
                end
            end
            n_cmp++;
            if ({wr_count, rd_count, afull_flag, aempty_flag} !==
                {m_wr(), m_rd(), m_wr() >= 12, m_rd() <= 2}) begin
                n_fail++;
                $display("FAIL wrap_drain[%0d]: wr %0d rd %0d af %b ae %b expected %0d/%0d/%b/%b",
                         r, wr_count, rd_count, afull_flag, aempty_flag,
                         m_wr(), m_rd(), m_wr() >= 12, m_rd() <= 2);
            end
        end
    endtask

`ifndef FRAME_FIFO_FWFT_EN
    task automatic test_back_to_back();
        logic [DW-1:0] want;
        bit fire;
        for (int k = 0; k < 6; k++) begin
            we = 1'b1;
            di = 9'(9'h1E0 + k);
            commit = 1'b1;
            re = 1'b1;
            fire = exp_q.size() > 0;
            cycle();
            model_write(9'(9'h1E0 + k));
            model_commit();
            if (fire) begin
                want = exp_q.pop_front();
                n_cmp++;
                if (dout !== want) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", k, dout, want);
                end
            end
            n_cmp++;
            if (rd_count !== m_rd()) begin
                n_fail++;
                $display("FAIL b2b_count[%0d]: got %0d expected %0d", k, rd_count, m_rd());
            end
        end
        we = 1'b0;
        commit = 1'b0;
        cycle();
        re = 1'b0;
        want = exp_q.pop_front();
        n_cmp++;
        if (dout !== want) begin
            n_fail++;
            $display("FAIL b2b_last: got %h expected %h", dout, want);
        end
        // Read while empty is ignored and the output holds.
        re = 1'b1;
        cycle();
        re = 1'b0;
        n_cmp++;
        if ({dout, empty_flag} !== {want, 1'b1}) begin
            n_fail++;
            $display("FAIL empty_read_hold: dout %h empty %b expected %h/1",
                     dout, empty_flag, want);
        end
    endtask
`endif

    task automatic test_commit_discard_same();
        logic [DW-1:0] got;
        wr_word(9'h1A0, 1'b0);
        wr_word(9'h1A1, 1'b0);
        we = 1'b1;
        di = 9'h1A2;
        commit = 1'b1;
        discard = 1'b1;
        cycle();
        {we, commit, discard} = 3'b000;
        model_write(9'h1A2);
        model_discard();
        n_cmp++;
        if ({drop_pulse, wr_count, empty_flag} !== {1'b1, m_wr(), 1'b1}) begin
            n_fail++;
            $display("FAIL commit_and_discard: drop %b wr %0d empty %b expected 1/%0d/1",
                     drop_pulse, wr_count, empty_flag, m_wr());
        end
        wr_word(9'h1A3, 1'b1);
        settle();
        read_word(got);
        n_cmp++;
        if (got !== 9'h1A3) begin
            n_fail++;
            $display("FAIL next_frame_clean: got %h expected 1A3", got);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) wr_word(9'(9'h150 + i), i == 2);
        wr_word(9'h160, 1'b0);
        wr_word(9'h161, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({empty_flag, aempty_flag, full_flag, afull_flag, drop_pulse, rd_count, wr_count}
            !== {5'b11000, 5'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL async_reset: flags %b rd %0d wr %0d expected 11000/0/0",
                     {empty_flag, aempty_flag, full_flag, afull_flag, drop_pulse},
                     rd_count, wr_count);
        end
        exp_q.delete();
        model_discard();
        #1;
        rst_n = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if ({empty_flag, wr_count} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL after_reset: empty %b wr %0d expected 1/0", empty_flag, wr_count);
        end
    endtask

`ifdef FRAME_FIFO_FWFT_EN
    task automatic test_fwft();
        wr_word(9'h1AA, 1'b1);
        n_cmp++;
        if (empty_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL fwft_commit_edge: empty %b expected 1", empty_flag);
        end
        cycle();
        n_cmp++;
        if ({dout, empty_flag} !== {9'h1AA, 1'b0}) begin
            n_fail++;
            $display("FAIL fwft_fallthrough: dout %h empty %b expected 1AA/0", dout, empty_flag);
        end
        re = 1'b1;
        cycle();
        re = 1'b0;
        void'(exp_q.pop_front());
        n_cmp++;
        if ({empty_flag, rd_count} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL fwft_ack: empty %b rd %0d expected 1/0", empty_flag, rd_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_visibility();
        test_discard();
        test_overflow();
        test_wrap();
`ifndef FRAME_FIFO_FWFT_EN
        test_back_to_back();
`endif
        test_commit_discard_same();
        test_reset_mid_frame();
`ifdef FRAME_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
